regfile_bist: RTL and testbench

REGFILE_BIST -- requirements
Module: regfile_bist

---
 rtl/regfile_bist.sv | 143 ++++++++++++++
 tb/tb_regfile_bist.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_bist.sv
// Built-in self test for a 32x32 register file with asynchronous read ports.
// Two passes of write / gated-write / dual-port read-compare over all 32 registers.
`timescale 1ns/1ps

module regfile_bist (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [7:0]  FailCount,
    output logic [4:0]  FirstFailAddr,
    output logic        FirstFailPort,
    output logic [31:0] WriteData,
    output logic [4:0]  WriteRegister,
    output logic        RegWrite,
    output logic [4:0]  ReadRegister1,
    output logic [4:0]  ReadRegister2,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2
);

    typedef enum logic [2:0] {IDLE, WRITE, HOLD, READ, DONE} bistState;

    localparam logic [31:0] PATTERN0 = 32'hA5A5A5A5;
    localparam logic [31:0] PATTERN1 = 32'h5A5A5A5A;

    bistState    state;
    logic        passIdx;
    logic [4:0]  addr;
    logic        firstFailSeen;

    logic [31:0] patternWord;
    logic [31:0] dataWord;
    logic [4:0]  mirrorAddr;
    logic [31:0] expected1;
    logic [31:0] expected2;
    logic        mismatch1;
    logic        mismatch2;
    logic [8:0]  failSum;

    // Port 2 walks the file top-down: 31-a is the bitwise complement of a.
    assign patternWord = passIdx ? PATTERN1 : PATTERN0;
    assign dataWord    = patternWord ^ {27'd0, addr};
    assign mirrorAddr  = ~addr;
    assign expected1   = (addr == 5'd0) ? 32'd0 : dataWord;
    assign expected2   = (mirrorAddr == 5'd0) ? 32'd0 : (patternWord ^ {27'd0, mirrorAddr});
    assign mismatch1   = (state == READ) && (ReadData1 != expected1);
    assign mismatch2   = (state == READ) && (ReadData2 != expected2);
    assign failSum     = {1'b0, FailCount} + 9'(mismatch1) + 9'(mismatch2);
    assign Pass        = Done && (FailCount == 8'd0);

    // NOTE: regfile-side outputs are decoded from the state registers rather than
    // registered, so the address and the asynchronous read data line up in one cycle.
    // Every output gets a default first so no latch can be inferred.
    always_comb begin
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 32'd0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        case (state)
            WRITE: begin
                RegWrite      = 1'b1;
                WriteRegister = addr;
                WriteData     = dataWord;
            end
            HOLD: begin
                WriteRegister = addr;
                WriteData     = ~dataWord;
            end
            READ: begin
                ReadRegister1 = addr;
                ReadRegister2 = mirrorAddr;
            end
            default: ;
        endcase
    end

    // NOTE: all state uses non-blocking assignments and a synchronous reset, so every
    // register in this block samples the same pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            passIdx       <= 1'b0;
            addr          <= 5'd0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            FailCount     <= 8'd0;
            FirstFailAddr <= 5'd0;
            FirstFailPort <= 1'b0;
            firstFailSeen <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state         <= WRITE;
                        passIdx       <= 1'b0;
                        addr          <= 5'd0;
                        Busy          <= 1'b1;
                        Done          <= 1'b0;
                        FailCount     <= 8'd0;
                        FirstFailAddr <= 5'd0;
                        FirstFailPort <= 1'b0;
                        firstFailSeen <= 1'b0;
                    end else if (state == DONE) begin
                        Done <= 1'b1;
                    end
                end
                WRITE: begin
                    addr <= addr + 5'd1;
                    if (addr == 5'd31) state <= HOLD;
                end
                HOLD: begin
                    addr <= addr + 5'd1;
                    if (addr == 5'd31) state <= READ;
                end
                READ: begin
                    addr      <= addr + 5'd1;
                    FailCount <= failSum[8] ? 8'hFF : failSum[7:0];
                    // Port 1 wins when both ports miss on the first failing cycle.
                    if (!firstFailSeen && (mismatch1 || mismatch2)) begin
                        firstFailSeen <= 1'b1;
                        FirstFailAddr <= mismatch1 ? addr : mirrorAddr;
                        FirstFailPort <= !mismatch1;
                    end
                    if (addr == 5'd31) begin
                        if (!passIdx) begin
                            passIdx <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            state <= DONE;
                            Busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Self-checking bench for regfile_bist: a behavioural register file with selectable
// faults, an expected cycle-by-cycle bus sequence, and a pass-level result model.
`timescale 1ns/1ps

module tb_regfile_bist;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Busy;
    logic        Done;
    logic        Pass;
    logic [7:0]  FailCount;
    logic [4:0]  FirstFailAddr;
    logic        FirstFailPort;
    logic [31:0] WriteData;
    logic [4:0]  WriteRegister;
    logic        RegWrite;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int checks = 0;
    int errors = 0;

    // 0 good, 1 write-enable ignored, 2 reg0 writable, 3 all regs written every cycle,
    // 4 good file with read corruption on the registers flagged in corruptSet
    int          mode = 0;
    logic [31:0] corruptSet = 32'd0;
    logic [31:0] corruptMask = 32'd0;
    logic [31:0] rf [32];

    regfile_bist dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Busy(Busy), .Done(Done), .Pass(Pass), .FailCount(FailCount),
        .FirstFailAddr(FirstFailAddr), .FirstFailPort(FirstFailPort),
        .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mode == 3) begin
            for (int i = 1; i < 32; i++) rf[i] <= WriteData;
        end else if ((RegWrite || mode == 1) && (WriteRegister != 5'd0 || mode == 2)) begin
            rf[WriteRegister] <= WriteData;
        end
    end

    always_comb begin
        ReadData1 = (ReadRegister1 == 5'd0 && mode != 2) ? 32'd0 : rf[ReadRegister1];
        ReadData2 = (ReadRegister2 == 5'd0 && mode != 2) ? 32'd0 : rf[ReadRegister2];
        if (mode == 4 && corruptSet[ReadRegister1]) ReadData1 = ReadData1 ^ corruptMask;
        if (mode == 4 && corruptSet[ReadRegister2]) ReadData2 = ReadData2 ^ corruptMask;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [63:0] busTuple();
        return {13'd0, Busy, Done, Pass, RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2};
    endfunction

    // Expected bus state k cycles after an accepted Start: 2 passes x 3 phases x 32 addresses.
    function automatic logic [63:0] seqTuple(input int k);
        int          passNum = k / 96;
        int          phase   = (k % 96) / 32;
        int          a       = k % 32;
        logic [31:0] d       = ((passNum == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A) ^ 32'(a);
        logic        rw      = (phase == 0);
        logic [4:0]  wr      = (phase < 2) ? 5'(a) : 5'd0;
        logic [31:0] wd      = (phase == 0) ? d : ((phase == 1) ? ~d : 32'd0);
        logic [4:0]  r1      = (phase == 2) ? 5'(a) : 5'd0;
        logic [4:0]  r2      = (phase == 2) ? 5'(31 - a) : 5'd0;
        return {13'd0, 1'b1, 1'b0, 1'b0, rw, wr, wd, r1, r2};
    endfunction

    // Read-corruption outcome: each read of a flagged register is one miss.
    task automatic corruptModel(input logic [31:0] cs, output int cnt, output int fAddr, output int fPort);
        bit seen = 0;
        cnt = 0; fAddr = 0; fPort = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 32; a++) begin
                bit m1 = cs[a];
                bit m2 = cs[31 - a];
                if (!seen && (m1 || m2)) begin
                    seen  = 1;
                    fAddr = m1 ? a : 31 - a;
                    fPort = m1 ? 0 : 1;
                end
                cnt = cnt + int'(m1) + int'(m2);
                if (cnt > 255) cnt = 255;
            end
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_bus"}, busTuple(), 64'd0);
        check({tag, "_result"}, {51'd0, FailCount, FirstFailAddr}, 64'd0);
        check({tag, "_port"}, 64'(FirstFailPort), 64'd0);
    endtask

    // Pulse Start, follow all 192 active cycles, then check the result one edge later.
    task automatic runFull(input string tag, input int expFail, input int expAddr,
                           input int expPort, input int repulseAt, input int resetAt);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 192; k++) begin
            check({tag, "_seq"}, busTuple(), seqTuple(k));
            if (k == resetAt) begin
                Reset = 1'b1;
                tick();
                Reset = 1'b0;
                checkIdle({tag, "_abort"});
                return;
            end
            if (k == repulseAt) Start = 1'b1;
            tick();
            Start = 1'b0;
        end
        check({tag, "_end"}, {61'd0, Busy, Done, RegWrite}, 64'd0);
        tick();
        check({tag, "_done"}, {61'd0, Busy, Done, Pass}, {61'd0, 1'b0, 1'b1, expFail == 0});
        check({tag, "_failCount"}, 64'(FailCount), 64'(expFail));
        check({tag, "_firstFail"}, {58'd0, FirstFailAddr, FirstFailPort}, {58'd0, 5'(expAddr), 1'(expPort)});
    endtask

    initial begin
        int cnt, fAddr, fPort;

        Reset = 1'b1;
        Start = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        Start = 1'b0;
        checkIdle("reset");
        tick();
        tick();
        checkIdle("idleHold");

        mode = 0;
        runFull("good", 0, 0, 0, -1, -1);
        runFull("repulse", 0, 0, 0, 50, -1);

        mode = 1;
        runFull("noWriteEnable", 124, 31, 1, -1, -1);
        mode = 2;
        runFull("reg0Writable", 4, 0, 0, -1, -1);
        mode = 3;
        runFull("writeAll", 124, 31, 1, -1, -1);

        mode = 0;
        runFull("abort", 0, 0, 0, -1, 100);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkIdle("afterAbort");
        end
        Reset = 1'b1;
        Start = 1'b1;
        tick();
        Reset = 1'b0;
        Start = 1'b0;
        checkIdle("resetOverStart");
        runFull("restart", 0, 0, 0, -1, -1);

        mode = 4;
        corruptMask = 32'h0000_0100;
        corruptSet  = (32'd1 << 5) | (32'd1 << 26);
        corruptModel(corruptSet, cnt, fAddr, fPort);
        runFull("bothPorts", cnt, fAddr, fPort, -1, -1);

        for (int r = 0; r < 4; r++) begin
            corruptMask = $urandom | 32'd1;
            corruptSet  = (r == 0) ? $urandom : ($urandom & $urandom & $urandom);
            corruptModel(corruptSet, cnt, fAddr, fPort);
            runFull("random", cnt, fAddr, fPort, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
